// File: rtl/sa_tile_sched.sv
`default_nettype none
// ============================================================================
//  sa_tile_sched : tiled GEMM scheduler driving one NxN systolic core
//  Rev 1.0
// ============================================================================
module sa_tile_sched #(
    parameter int WIDTH  = 8,
    parameter int ACC    = 32,
    parameter int N      = 3,
    parameter int ADDR_W = 16,
    parameter int TW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic [TW-1:0]        cfg_m_tiles_i,
    input  logic [TW-1:0]        cfg_k_tiles_i,
    input  logic [TW-1:0]        cfg_p_tiles_i,
    input  logic [ADDR_W-1:0]    cfg_a_base_i,
    input  logic [ADDR_W-1:0]    cfg_b_base_i,
    input  logic [ADDR_W-1:0]    cfg_c_base_i,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [WIDTH-1:0]     rd_data_i,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [ACC-1:0]       wr_data_o,
    output logic                 core_rst_n_o,
    output logic                 core_start_o,
    input  logic                 core_done_i,
    output logic [N*N*WIDTH-1:0] core_a_mem_o,
    output logic [N*N*WIDTH-1:0] core_b_mem_o,
    input  logic [N*N*ACC-1:0]   core_c_out_i
);

    localparam int NN       = N * N;
    localparam int LOAD_LEN = 2 * NN;
    localparam int CW       = $clog2(LOAD_LEN + 1);
    localparam int OW       = $clog2(LOAD_LEN);
    localparam int EW       = (NN > 1) ? $clog2(NN) : 1;
    localparam int RW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_RUN, S_ACCUM, S_WRITE, S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, done_q;
    logic [TW-1:0]      m_q, k_q, p_q, mi_q, pi_q, ki_q;
    logic [ADDR_W-1:0]  a_base_q, b_base_q, c_base_q;
    logic [CW-1:0]      cnt_q;
    logic [RW-1:0]      r_q, c_q;
    logic               cap_q;
    logic [OW-1:0]      cap_idx_q;
    logic [WIDTH-1:0]   op_q  [LOAD_LEN];
    logic [ACC-1:0]     acc_q [NN];
    logic               core_clr;

    logic               accept, cfg_zero, load_issue, last_k, last_p, last_m, wr_last;
    logic [ADDR_W-1:0]  w_kd, w_pd, w_mrow, w_krow, w_kcol, w_pcol;
    logic [ADDR_W-1:0]  a_addr, b_addr, c_addr;

    assign accept     = (state_q == S_IDLE) && start_i && !busy_q;
    assign cfg_zero   = (cfg_m_tiles_i == '0) || (cfg_k_tiles_i == '0) || (cfg_p_tiles_i == '0);
    assign load_issue = (state_q == S_LOAD) && (cnt_q < CW'(LOAD_LEN));
    assign last_k     = (ki_q == k_q - TW'(1));
    assign last_p     = (pi_q == p_q - TW'(1));
    assign last_m     = (mi_q == m_q - TW'(1));
    assign wr_last    = (cnt_q == CW'(NN - 1));

    // r_q/c_q walk the tile in raster order; the same pair serves A, B and C.
    assign w_kd   = ADDR_W'(k_q) * N_A;
    assign w_pd   = ADDR_W'(p_q) * N_A;
    assign w_mrow = ADDR_W'(mi_q) * N_A + ADDR_W'(r_q);
    assign w_krow = ADDR_W'(ki_q) * N_A + ADDR_W'(r_q);
    assign w_kcol = ADDR_W'(ki_q) * N_A + ADDR_W'(c_q);
    assign w_pcol = ADDR_W'(pi_q) * N_A + ADDR_W'(c_q);
    assign a_addr = a_base_q + w_mrow * w_kd + w_kcol;
    assign b_addr = b_base_q + w_krow * w_pd + w_pcol;
    assign c_addr = c_base_q + w_mrow * w_pd + w_pcol;

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign core_rst_n_o = rst_n & ~core_clr;

    for (genvar e = 0; e < NN; e++) begin : g_pack
        assign core_a_mem_o[e*WIDTH +: WIDTH] = op_q[e];
        assign core_b_mem_o[e*WIDTH +: WIDTH] = op_q[NN+e];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        rd_en_o      = 1'b0;
        rd_addr_o    = '0;
        wr_en_o      = 1'b0;
        wr_addr_o    = '0;
        wr_data_o    = '0;
        core_start_o = 1'b0;
        core_clr     = 1'b0;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = cfg_zero ? S_FIN : S_LOAD;
            S_LOAD: begin
                if (load_issue) begin
                    rd_en_o   = 1'b1;
                    rd_addr_o = (cnt_q < CW'(NN)) ? a_addr : b_addr;
                end
                if (cnt_q == CW'(LOAD_LEN)) state_d = S_CLR;
            end
            S_CLR: begin
                core_clr = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                core_start_o = (cnt_q == '0);
                if (core_done_i) state_d = S_ACCUM;
            end
            S_ACCUM: state_d = last_k ? S_WRITE : S_LOAD;
            S_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = c_addr;
                wr_data_o = acc_q[EW'(cnt_q)];
                if (wr_last) state_d = (last_p && last_m) ? S_FIN : S_LOAD;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_q       <= '0;
            k_q       <= '0;
            p_q       <= '0;
            mi_q      <= '0;
            pi_q      <= '0;
            ki_q      <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            c_base_q  <= '0;
            cnt_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
            for (int i = 0; i < LOAD_LEN; i++) op_q[i] <= '0;
            for (int i = 0; i < NN; i++) acc_q[i] <= '0;
        end else begin
            done_q    <= (state_q == S_FIN);
            busy_q    <= accept || (state_q != S_IDLE);
            cap_q     <= load_issue;
            cap_idx_q <= OW'(cnt_q);
            if (cap_q) op_q[cap_idx_q] <= rd_data_i;

            // Per-state counter restarts on every state change.
            if (state_d != state_q) begin
                cnt_q <= '0;
                r_q   <= '0;
                c_q   <= '0;
            end else if (state_q == S_LOAD || state_q == S_WRITE) begin
                cnt_q <= cnt_q + CW'(1);
                if (c_q == RW'(N - 1)) begin
                    c_q <= '0;
                    r_q <= (r_q == RW'(N - 1)) ? '0 : r_q + RW'(1);
                end else begin
                    c_q <= c_q + RW'(1);
                end
            end else if (state_q == S_RUN) begin
                cnt_q <= CW'(1);
            end

            case (state_q)
                S_IDLE: if (accept) begin
                    m_q      <= cfg_m_tiles_i;
                    k_q      <= cfg_k_tiles_i;
                    p_q      <= cfg_p_tiles_i;
                    a_base_q <= cfg_a_base_i;
                    b_base_q <= cfg_b_base_i;
                    c_base_q <= cfg_c_base_i;
                    mi_q     <= '0;
                    pi_q     <= '0;
                    ki_q     <= '0;
                    for (int i = 0; i < NN; i++) acc_q[i] <= '0;
                end
                S_ACCUM: begin
                    for (int i = 0; i < NN; i++) acc_q[i] <= acc_q[i] + core_c_out_i[i*ACC +: ACC];
                    if (!last_k) ki_q <= ki_q + TW'(1);
                end
                S_WRITE: if (wr_last) begin
                    for (int i = 0; i < NN; i++) acc_q[i] <= '0;
                    ki_q <= '0;
                    if (last_p) begin
                        pi_q <= '0;
                        mi_q <= mi_q + TW'(1);
                    end else begin
                        pi_q <= pi_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
